// File: rtl/dm_emu_defs_pkg.sv
// Shared EMU audio-path definitions: sample/buffer geometry, ADC frame
// defaults and the capture FSM state type.
package dm_emu_defs_pkg;

  localparam int SAMPLE_W       = 12;
  localparam int BLOCK_LEN      = 512;
  localparam int BUF_ADDR_W     = 10;
  localparam int IDX_W          = BUF_ADDR_W - 1;
  localparam int ADC_SCLK_DIV   = 4;
  localparam int ADC_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STORE = 2'd3
  } adc_state_t;

endpackage

// File: rtl/dm_tlv2541_adc_interface_ram.sv
// Ping-pong sample buffer: simple dual-port RAM with one write port and one
// registered read port; only the read register is reset.
module dm_pingpong_ram
  import dm_emu_defs_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W) - 1];

  // Write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/dm_tlv2541_adc_interface.sv
// TLV2541 capture front end: one serial conversion frame per strobe, samples
// written into alternating 512-entry halves of the ping-pong RAM.
module dm_tlv2541_adc_interface
  import dm_emu_defs_pkg::*;
#(
  parameter int SCLK_DIV   = ADC_SCLK_DIV,
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int DATA_BITS  = SAMPLE_W,
  parameter int TWOS_COMP  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SampleStrobe,
  output logic                  ADCCS,
  output logic                  ADCSCLK,
  input  logic                  ADCSDO,
  input  logic [IDX_W-1:0]      FFTReadIndex,
  output logic [DATA_BITS-1:0]  FFTReadData,
  output logic                  BlockReady,
  output logic [BUF_ADDR_W-1:0] ADCLocationWritingTo,
  output logic                  OverrunError
);

  localparam int PH_W = $clog2(SCLK_DIV);
  localparam logic [DATA_BITS-1:0] MSB_MASK = {(TWOS_COMP != 0), {(DATA_BITS-1){1'b0}}};

  adc_state_t            state_r, state_s;
  logic [PH_W-1:0]       phase_r, phase_s;
  logic [4:0]            bit_r, bit_s;
  logic [FRAME_BITS-1:0] shift_r, shift_s;
  logic                  cs_r, cs_s, sclk_r, sclk_s;
  logic                  half_r, half_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic                  ready_r, ready_s, overrun_r, overrun_s;
  logic                  we_s, phase_last_s;
  logic [DATA_BITS-1:0]  sample_s;

  assign phase_last_s = (phase_r == PH_W'(SCLK_DIV - 1));
  // Unipolar ADC code becomes two's complement by flipping the MSB.
  assign sample_s     = shift_r[FRAME_BITS-1 -: DATA_BITS] ^ MSB_MASK;

  // Next-state and next-output logic for the conversion frame.
  always_comb begin
    state_s   = state_r;
    phase_s   = phase_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    cs_s      = cs_r;
    sclk_s    = sclk_r;
    half_s    = half_r;
    idx_s     = idx_r;
    ready_s   = 1'b0;
    overrun_s = overrun_r;
    we_s      = 1'b0;
    if (SampleStrobe && (state_r != ST_IDLE)) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (SampleStrobe) begin
          state_s = ST_SETUP;
          cs_s    = 1'b0;
          phase_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (phase_last_s) begin
          state_s = ST_SHIFT;
          phase_s = '0;
          bit_s   = 5'd0;
        end else begin
          phase_s = phase_r + PH_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!phase_last_s) begin
          phase_s = phase_r + PH_W'(1);
        end else if (!sclk_r) begin
          // End of low phase: SCLK rises and SDO is captured on the same edge.
          phase_s = '0;
          sclk_s  = 1'b1;
          shift_s = {shift_r[FRAME_BITS-2:0], ADCSDO};
        end else begin
          phase_s = '0;
          sclk_s  = 1'b0;
          if (bit_r == 5'(FRAME_BITS - 1)) begin
            state_s = ST_STORE;
          end else begin
            bit_s = bit_r + 5'd1;
          end
        end
      end
      ST_STORE: begin
        we_s    = 1'b1;
        cs_s    = 1'b1;
        state_s = ST_IDLE;
        if (idx_r == IDX_W'(BLOCK_LEN - 1)) begin
          idx_s   = '0;
          half_s  = ~half_r;
          ready_s = 1'b1;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_s    = 1'b1;
        sclk_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      phase_r   <= '0;
      bit_r     <= 5'd0;
      shift_r   <= '0;
      cs_r      <= 1'b1;
      sclk_r    <= 1'b0;
      half_r    <= 1'b0;
      idx_r     <= '0;
      ready_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      phase_r   <= phase_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      cs_r      <= cs_s;
      sclk_r    <= sclk_s;
      half_r    <= half_s;
      idx_r     <= idx_s;
      ready_r   <= ready_s;
      overrun_r <= overrun_s;
    end
  end

  // Writer fills {half, idx} while the reader sees the other half.
  dm_pingpong_ram #(
    .DATA_W (DATA_BITS),
    .ADDR_W (BUF_ADDR_W)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (we_s && !RST),
    .wr_addr ({half_r, idx_r}),
    .wr_data (sample_s),
    .rd_addr ({~half_r, FFTReadIndex}),
    .rd_data (FFTReadData)
  );

  assign ADCCS                = cs_r;
  assign ADCSCLK              = sclk_r;
  assign BlockReady           = ready_r;
  assign OverrunError         = overrun_r;
  assign ADCLocationWritingTo = {half_r, idx_r};

endmodule

// File: tb/tb_dm_tlv2541_adc_interface.sv
// Bench: instance a (defaults, raw codes) for frame timing, overrun and abort;
// instance b (fast frame, two's complement) for the ping-pong fill/wrap/read path.
module tb_dm_tlv2541_adc_interface;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_strobe = 1'b0, a_cs, a_sclk, a_sdo, a_ready, a_ovr;
  logic [8:0] a_ridx = 9'd0;
  logic [11:0] a_rdata, a_code = 12'h000;
  logic [9:0] a_loc;
  logic b_strobe = 1'b0, b_cs, b_sclk, b_sdo, b_ready, b_ovr;
  logic [8:0] b_ridx = 9'd0;
  logic [11:0] b_rdata, b_code = 12'h000;
  logic [9:0] b_loc;

  dm_tlv2541_adc_interface #(.SCLK_DIV(4), .FRAME_BITS(16), .DATA_BITS(12), .TWOS_COMP(0)) u_a (
    .CLK(clk), .RST(rst), .SampleStrobe(a_strobe), .ADCCS(a_cs), .ADCSCLK(a_sclk),
    .ADCSDO(a_sdo), .FFTReadIndex(a_ridx), .FFTReadData(a_rdata), .BlockReady(a_ready),
    .ADCLocationWritingTo(a_loc), .OverrunError(a_ovr));

  dm_tlv2541_adc_interface #(.SCLK_DIV(2), .FRAME_BITS(12), .DATA_BITS(12), .TWOS_COMP(1)) u_b (
    .CLK(clk), .RST(rst), .SampleStrobe(b_strobe), .ADCCS(b_cs), .ADCSCLK(b_sclk),
    .ADCSDO(b_sdo), .FFTReadIndex(b_ridx), .FFTReadData(b_rdata), .BlockReady(b_ready),
    .ADCLocationWritingTo(b_loc), .OverrunError(b_ovr));

  // ADC models: load the frame word at CS fall, advance one bit per SCLK fall.
  logic [15:0] a_word = 16'h0000;
  logic [11:0] b_word = 12'h000;
  int a_bit = 0, b_bit = 0, a_rises = 0, a_lows = 0;
  logic a_cs_q = 1'b1, a_sclk_q = 1'b0, b_cs_q = 1'b1, b_sclk_q = 1'b0;

  always @(negedge clk) begin
    if (a_cs_q && !a_cs) begin a_word = {a_code, 4'h0}; a_bit = 0; end
    else if (!a_cs && a_sclk_q && !a_sclk) a_bit = a_bit + 1;
    if (!a_sclk_q && a_sclk) a_rises = a_rises + 1;
    if (!a_cs) a_lows = a_lows + 1;
    a_sdo = (a_bit < 16) ? a_word[15 - a_bit] : 1'b0;
    a_cs_q = a_cs;
    a_sclk_q = a_sclk;
  end

  always @(negedge clk) begin
    if (b_cs_q && !b_cs) begin b_word = b_code; b_bit = 0; end
    else if (!b_cs && b_sclk_q && !b_sclk) b_bit = b_bit + 1;
    b_sdo = (b_bit < 12) ? b_word[11 - b_bit] : 1'b0;
    b_cs_q = b_cs;
    b_sclk_q = b_sclk;
  end

  int n_total = 0, n_pass = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic pulse_a();
    a_strobe = 1'b1; tick(); a_strobe = 1'b0;
  endtask

  task automatic pulse_b();
    b_strobe = 1'b1; tick(); b_strobe = 1'b0;
  endtask

  // Bounded waits for the frame's CS release; lat is ticks after the strobe edge.
  task automatic wait_a_done(output int lat);
    lat = 0;
    while (a_cs == 1'b0 && lat < 400) begin tick(); lat++; end
  endtask

  task automatic wait_b_done(output int lat);
    lat = 0;
    while (b_cs == 1'b0 && lat < 200) begin tick(); lat++; end
  endtask

  // Expected stored value for a unipolar code in two's complement: offset by half scale.
  function automatic logic [11:0] to_signed_code(input logic [11:0] code);
    return 12'((int'(code) + 2048) % 4096);
  endfunction

  typedef struct { logic [11:0] code; logic [11:0] stored; } vec_t;
  vec_t vecs [6];
  logic [11:0] mdl_a [0:1023];
  logic [11:0] mdl_b [0:1023];

  initial begin
    int lat, r0, l0, last_acc, exp_loc, gap, base;
    logic exp_ovr;
    logic [11:0] code;

    vecs[0] = '{code: 12'h000, stored: 12'h800};
    vecs[1] = '{code: 12'h800, stored: 12'h000};
    vecs[2] = '{code: 12'hFFF, stored: 12'h7FF};
    vecs[3] = '{code: 12'h7FF, stored: 12'hFFF};
    vecs[4] = '{code: 12'h123, stored: 12'h923};
    vecs[5] = '{code: 12'hABC, stored: 12'h2BC};

    do_reset();
    check("rst_a_cs", a_cs, 1);
    check("rst_a_sclk", a_sclk, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_a_ovr", a_ovr, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_a_loc", a_loc, 0);
    check("rst_b_cs", b_cs, 1);
    check("rst_b_loc", b_loc, 0);
    check("rst_b_rdata", b_rdata, 0);

    // Single raw frame with default timing.
    r0 = a_rises; l0 = a_lows;
    a_code = 12'hABC;
    pulse_a();
    wait_a_done(lat);
    check("t1_latency", lat, 133);
    check("t1_cs_low_cycles", a_lows - l0, 133);
    check("t1_sclk_pulses", a_rises - r0, 16);
    check("t1_sclk_idle", a_sclk, 0);
    check("t1_ram0", u_a.u_ram.mem_r[0], 12'hABC);
    check("t1_loc", a_loc, 1);
    check("t1_no_ready", a_ready, 0);
    a_code = 12'h000;

    // Random strobe spacing: strobes closer than one frame are dropped and flag overrun.
    mdl_a[0] = 12'hABC; exp_loc = 1; exp_ovr = 1'b0; last_acc = -100000;
    for (int i = 0; i < 12; i++) begin
      code = 12'($urandom);
      gap = $urandom_range(40, 200);
      a_code = code;
      pulse_a();
      if (cyc - last_acc >= 134) begin
        last_acc = cyc;
        mdl_a[exp_loc] = code;
        exp_loc = exp_loc + 1;
      end else begin
        exp_ovr = 1'b1;
      end
      repeat (gap) tick();
    end
    repeat (140) tick();
    check("rnd_loc", a_loc, exp_loc);
    check("rnd_ovr", a_ovr, exp_ovr);
    for (int k = 1; k < exp_loc; k++) check("rnd_ram", u_a.u_ram.mem_r[k], mdl_a[k]);

    // Second strobe 50 cycles into a frame.
    do_reset();
    check("t5_ovr_cleared", a_ovr, 0);
    a_code = 12'h3C5;
    pulse_a();
    repeat (49) tick();
    pulse_a();
    check("t5_ovr_set", a_ovr, 1);
    wait_a_done(lat);
    check("t5_remaining_latency", lat, 83);
    check("t5_ram0", u_a.u_ram.mem_r[0], 12'h3C5);
    check("t5_loc", a_loc, 1);
    repeat (20) tick();
    check("t5_no_second_frame", a_cs, 1);
    check("t5_ovr_sticky", a_ovr, 1);
    check("t5_loc_after", a_loc, 1);

    // Reset during bit 7 aborts the frame without a RAM write.
    a_code = 12'h222; pulse_a(); wait_a_done(lat);
    check("t6_ram1_pre", u_a.u_ram.mem_r[1], 12'h222);
    do_reset();
    a_code = 12'h333; pulse_a(); wait_a_done(lat);
    check("t6_loc_pre", a_loc, 1);
    a_code = 12'h777;
    pulse_a();
    repeat (61) tick();
    rst = 1'b1;
    tick();
    check("t6_abort_cs", a_cs, 1);
    check("t6_abort_sclk", a_sclk, 0);
    rst = 1'b0;
    repeat (150) tick();
    check("t6_no_write", u_a.u_ram.mem_r[1], 12'h222);
    check("t6_no_ready", a_ready, 0);
    check("t6_loc_reset", a_loc, 0);
    check("t6_idle_cs", a_cs, 1);
    a_code = 12'h444; pulse_a(); wait_a_done(lat);
    check("t6_next_latency", lat, 133);
    check("t6_next_ram0", u_a.u_ram.mem_r[0], 12'h444);
    check("t6_next_loc", a_loc, 1);

    // Two's-complement conversion table on the fast instance.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b_code = vecs[i].code;
      pulse_b();
      wait_b_done(lat);
      check("tc_latency", lat, 51);
      check("tc_stored", u_b.u_ram.mem_r[i], vecs[i].stored);
      check("tc_loc", b_loc, i + 1);
    end

    // Fill both halves: ramp into the first, random codes into the second.
    do_reset();
    for (int n = 0; n < 1024; n++) begin
      if (n_total - n_pass > 100) break;
      code = (n < 512) ? 12'(n) : 12'($urandom);
      mdl_b[n] = to_signed_code(code);
      b_code = code;
      repeat ($urandom_range(0, 3)) tick();
      pulse_b();
      wait_b_done(lat);
      check("fill_latency", lat, 51);
      check("fill_ready", b_ready, ((n + 1) % 512 == 0) ? 1 : 0);
      check("fill_loc", b_loc, (n + 1) % 1024);
      if ((n + 1) % 512 == 0) begin
        base = (n == 511) ? 0 : 512;
        b_ridx = 9'd0;
        tick();
        check("ready_one_cycle", b_ready, 0);
        for (int k = 0; k < 512; k++) begin
          check("half_read", b_rdata, mdl_b[base + k]);
          b_ridx = 9'(k + 1);
          tick();
        end
      end
    end
    b_code = 12'h0AA;
    pulse_b();
    wait_b_done(lat);
    check("overwrite_lower", u_b.u_ram.mem_r[0], to_signed_code(12'h0AA));
    check("overwrite_loc", b_loc, 1);
    check("b_no_overrun", b_ovr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
